id00001001_stream_sequencer: RTL and testbench

//  Core-side controller for AIP 00001001. Sequences a job from the AIP interface.

---
 rtl/id00001001_stream_sequencer.sv | 172 +++++++++++++++++
 tb/tb_id00001001_stream_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/id00001001_stream_sequencer.sv
// Purpose: core-side job sequencer; streams N words MemIn0 -> datapath -> MemOut0, drives busy/done.
// Latency: start at cycle 0 -> busy and first read at 1, first datapath word at 3, done one cycle after last write.
// Backpressure: one-word hold register plus the memory output stage; dp_in_ready low stalls reads, en_s low freezes all state.
//
// Ports:
//   clk, rst_a (sync, active-high), en_s (clock enable)
//   start_IPcore / data_ConfigReg[AW:0]   : job start and word count N (clamped to 2**AW)
//   rd_addr_MemIn0 / data_MemIn0          : MemIn0 read port, data one cycle after address
//   dp_in_valid/dp_in_ready/dp_in_data    : words to the datapath
//   dp_out_valid/dp_out_ready/dp_out_data : results from the datapath
//   wr_en/wr_addr/data_MemOut0            : MemOut0 write port
//   status_IPcore[0] = busy, int_IPcore[0] = done pulse
module id00001001_stream_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH_MEMI = 6,
    parameter int ADDR_WIDTH_MEMO = 6,
    parameter int STATUS_WIDTH    = 8,
    parameter int INT_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst_a,
    input  logic                       en_s,
    input  logic                       start_IPcore,
    input  logic [DATA_WIDTH-1:0]      data_ConfigReg,
    output logic [ADDR_WIDTH_MEMI-1:0] rd_addr_MemIn0,
    input  logic [DATA_WIDTH-1:0]      data_MemIn0,
    output logic                       dp_in_valid,
    output logic [DATA_WIDTH-1:0]      dp_in_data,
    input  logic                       dp_in_ready,
    input  logic                       dp_out_valid,
    input  logic [DATA_WIDTH-1:0]      dp_out_data,
    output logic                       dp_out_ready,
    output logic [DATA_WIDTH-1:0]      data_MemOut0,
    output logic [ADDR_WIDTH_MEMO-1:0] wr_addr_MemOut0,
    output logic                       wr_en_MemOut0,
    output logic [STATUS_WIDTH-1:0]    status_IPcore,
    output logic [INT_WIDTH-1:0]       int_IPcore
);

    localparam int AW = ADDR_WIDTH_MEMI;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] MAX_N  = {1'b1, {AW{1'b0}}};
    localparam logic [CW-1:0] ONE_C  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_A  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         n_q;
    logic [CW-1:0]         rd_cnt_q;
    logic [CW-1:0]         wr_cnt_q;
    logic                  rd_pending_q;
    logic                  hold_valid_q;
    logic [DATA_WIDTH-1:0] hold_data_q;

    logic [CW-1:0] cfg_n;
    logic [CW-1:0] n_clamp;
    logic          cfg_unused;
    logic          run;
    logic          xfer;
    logic          hold_load;
    logic          rd_issue;
    logic          wr_fire;

    assign cfg_n      = data_ConfigReg[AW:0];
    assign n_clamp    = (cfg_n > MAX_N) ? MAX_N : cfg_n;
    assign cfg_unused = ^data_ConfigReg[DATA_WIDTH-1:AW+1];

    assign run  = en_s && (state_q == S_RUN);
    assign xfer = run && hold_valid_q && dp_in_ready;

    // The in-flight word lands in the hold register once the hold is free
    // or being emptied this cycle; until then the memory keeps re-reading
    // its address, so the memory output acts as the second buffer stage.
    assign hold_load = run && rd_pending_q && (!hold_valid_q || xfer);

    // A new read may be issued whenever the previous one is not stuck,
    // which sustains one word per clock with dp_in_ready held high.
    assign rd_issue = run && (rd_cnt_q < n_q) && (!rd_pending_q || hold_load);

    assign wr_fire = run && dp_out_valid && (wr_cnt_q < n_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_q <= S_IDLE;
        end else if (en_s) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_IPcore) begin
                    state_d = (n_clamp != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (wr_fire && (wr_cnt_q == n_q - ONE_C)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Job counters and read buffering
    always_ff @(posedge clk) begin
        if (rst_a) begin
            n_q          <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            rd_pending_q <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else if (en_s) begin
            if (state_q == S_IDLE) begin
                if (start_IPcore) begin
                    n_q          <= n_clamp;
                    rd_cnt_q     <= '0;
                    wr_cnt_q     <= '0;
                    rd_pending_q <= 1'b0;
                    hold_valid_q <= 1'b0;
                end
            end else if (state_q == S_RUN) begin
                if (rd_issue) begin
                    rd_cnt_q     <= rd_cnt_q + ONE_C;
                    rd_pending_q <= 1'b1;
                end else if (hold_load) begin
                    rd_pending_q <= 1'b0;
                end
                if (hold_load) begin
                    hold_valid_q <= 1'b1;
                    hold_data_q  <= data_MemIn0;
                end else if (xfer) begin
                    hold_valid_q <= 1'b0;
                end
                if (wr_fire) begin
                    wr_cnt_q <= wr_cnt_q + ONE_C;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        status_IPcore    = '0;
        int_IPcore       = '0;
        status_IPcore[0] = (state_q == S_RUN);
        int_IPcore[0]    = (state_q == S_DONE);

        // While a read is stuck, present its address again so the memory
        // output still carries that word on the next cycle.
        if (rd_pending_q && !rd_issue) begin
            rd_addr_MemIn0 = rd_cnt_q[AW-1:0] - ONE_A;
        end else begin
            rd_addr_MemIn0 = rd_cnt_q[AW-1:0];
        end

        dp_in_valid     = run && hold_valid_q;
        dp_in_data      = hold_data_q;
        dp_out_ready    = run && (wr_cnt_q < n_q);
        wr_en_MemOut0   = wr_fire;
        wr_addr_MemOut0 = wr_cnt_q[ADDR_WIDTH_MEMO-1:0];
        data_MemOut0    = dp_out_data;
    end

endmodule

// File: tb/tb_id00001001_stream_sequencer.sv
`timescale 1ns/1ps
module tb_id00001001_stream_sequencer;
    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_a, en_s, start;
    logic [DW-1:0] cfg;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] data_in;
    logic          dp_in_valid, dp_in_ready, dp_out_valid, dp_out_ready;
    logic [DW-1:0] dp_in_data, dp_out_data, data_out;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic [7:0]    status, intr;

    int applied = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    id00001001_stream_sequencer dut (
        .clk(clk), .rst_a(rst_a), .en_s(en_s), .start_IPcore(start),
        .data_ConfigReg(cfg), .rd_addr_MemIn0(rd_addr), .data_MemIn0(data_in),
        .dp_in_valid(dp_in_valid), .dp_in_data(dp_in_data), .dp_in_ready(dp_in_ready),
        .dp_out_valid(dp_out_valid), .dp_out_data(dp_out_data), .dp_out_ready(dp_out_ready),
        .data_MemOut0(data_out), .wr_addr_MemOut0(wr_addr), .wr_en_MemOut0(wr_en),
        .status_IPcore(status), .int_IPcore(intr)
    );

    // Synchronous-read source memory
    logic [DW-1:0] mem_in [0:63];
    always @(posedge clk) data_in <= mem_in[rd_addr];

    // Datapath: one registered stage computing x+1, never drops a result
    logic          dpv = 1'b0;
    logic [DW-1:0] dpd = '0;
    logic          stim_rdy;
    assign dp_in_ready  = stim_rdy && (!dpv || dp_out_ready);
    assign dp_out_valid = dpv;
    assign dp_out_data  = dpd;
    always @(posedge clk) begin
        if (rst_a) dpv <= 1'b0;
        else if (dp_in_valid && dp_in_ready) begin
            dpv <= 1'b1;
            dpd <= dp_in_data + 1;
        end else if (dp_out_valid && dp_out_ready) dpv <= 1'b0;
    end

    // Observers, sampled mid-cycle
    logic [DW-1:0] in_q[$];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            strobe_viol, hold_viol;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_dat;
    always @(negedge clk) begin
        if (dp_in_valid && dp_in_ready) in_q.push_back(dp_in_data);
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(data_out);
        end
        if (!en_s && (dp_in_valid || dp_out_ready || wr_en)) strobe_viol++;
        if (rst_a) prev_stall = 0;
        else if (en_s) begin
            if (prev_stall && !(dp_in_valid && dp_in_data == prev_dat)) hold_viol++;
            prev_stall = dp_in_valid && !dp_in_ready;
            prev_dat   = dp_in_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one job; mode 0 = always ready, 1 = ready 1010..., 2 = random ready.
    // restart_at: cycle of an extra (ignored) start; off_at/off_len: en_s low window.
    task automatic run_job(input string tag, input logic [DW-1:0] cfg_v, input int mode,
                           input int restart_at, input int off_at, input int off_len,
                           input int exp_n, input int exp_done);
        int t0, rel, done_at, busy_n, int_n, bad_w, bad_i;
        bit fin;
        in_q.delete(); wa_q.delete(); wd_q.delete();
        strobe_viol = 0; hold_viol = 0;
        done_at = -1; busy_n = 0; int_n = 0; fin = 0;
        @(posedge clk); #1;
        cfg = cfg_v; start = 1'b1; en_s = 1'b1; stim_rdy = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 600 && !fin; k++) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            start = (rel == restart_at);
            if (rel == restart_at) cfg = 32'd2;
            en_s = !(off_at >= 0 && rel >= off_at && rel < off_at + off_len);
            case (mode)
                0:       stim_rdy = 1'b1;
                1:       stim_rdy = (rel % 2 == 0);
                default: stim_rdy = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (status[0]) busy_n++;
            if (intr[0]) begin
                int_n++;
                if (done_at < 0) done_at = rel;
            end
            if (done_at >= 0 && rel > done_at + 2) fin = 1;
        end
        start = 1'b0; en_s = 1'b1; stim_rdy = 1'b1;
        check({tag, " finished"}, fin, 1);
        if (exp_done >= 0) check({tag, " done_cycle"}, done_at, exp_done);
        check({tag, " busy_cycles"}, busy_n, (exp_n == 0) ? 0 : done_at - 1);
        check({tag, " int_pulses"}, int_n, 1);
        check({tag, " write_count"}, wa_q.size(), exp_n);
        bad_w = 0;
        foreach (wa_q[i]) if (wa_q[i] != AW'(i) || wd_q[i] != mem_in[i] + 1) bad_w++;
        check({tag, " write_content"}, bad_w, 0);
        check({tag, " stream_count"}, in_q.size(), exp_n);
        bad_i = 0;
        foreach (in_q[i]) if (in_q[i] != mem_in[i]) bad_i++;
        check({tag, " stream_order"}, bad_i, 0);
        check({tag, " hold_stable"}, hold_viol, 0);
        check({tag, " en_strobes"}, strobe_viol, 0);
    endtask

    typedef struct {
        string         name;
        logic [DW-1:0] cfg;
        int            mode;
        int            exp_n;
        int            exp_done;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n_exp;
        logic [DW-1:0] rc;
        tbl[0] = '{"n4",       32'd4,          0, 4,  8};
        tbl[1] = '{"n0",       32'd0,          0, 0,  1};
        tbl[2] = '{"n8_tog",   32'd8,          1, 8, -1};
        tbl[3] = '{"n127",     32'd127,        0, 64, 68};
        tbl[4] = '{"n1",       32'd1,          0, 1,  5};
        tbl[5] = '{"hi_bits",  32'hABCD_0003,  0, 3,  7};
        tbl[6] = '{"n65",      32'h0000_0041,  1, 64, -1};

        foreach (mem_in[i]) mem_in[i] = $urandom;
        rst_a = 1'b1; en_s = 1'b1; start = 1'b1; cfg = 32'd4; stim_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst status", status, 0);
        check("rst int", intr, 0);
        check("rst rd_addr", rd_addr, 0);
        check("rst dp_in_valid", dp_in_valid, 0);
        check("rst dp_out_ready", dp_out_ready, 0);
        check("rst wr_en", wr_en, 0);
        #1; rst_a = 1'b0; start = 1'b0;

        foreach (tbl[i])
            run_job(tbl[i].name, tbl[i].cfg, tbl[i].mode, -1, -1, 0, tbl[i].exp_n, tbl[i].exp_done);

        // Start ignored in RUN and a 3-cycle enable gap: adds exactly 3 cycles
        run_job("restart_enoff", 32'd8, 0, 3, 5, 3, 8, 15);

        // Reset in the middle of a 16-word job
        @(posedge clk); #1; cfg = 32'd16; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1; rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst status", status, 0);
        check("midrst int", intr, 0);
        check("midrst dp_in_valid", dp_in_valid, 0);
        check("midrst dp_out_ready", dp_out_ready, 0);
        check("midrst wr_en", wr_en, 0);
        check("midrst rd_addr", rd_addr, 0);
        #1; rst_a = 1'b0;
        run_job("after_rst", 32'd5, 0, -1, -1, 0, 5, 9);

        // Randomized jobs against the count/clamp rule
        for (int r = 0; r < 6; r++) begin
            foreach (mem_in[i]) mem_in[i] = $urandom;
            rc = $urandom;
            n_exp = (rc[6:0] > 7'd64) ? 64 : int'(rc[6:0]);
            run_job($sformatf("rand%0d", r), rc, 2, -1, -1, 0, n_exp, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
